// File: rtl/crc8_tx_append.sv
// CRC-8 transmit appender: passes payload bytes through a single output
// register and appends the running CRC as a final byte marked by o_last.
module crc8_tx_append #(
  parameter int DATA_LENGTH       = 32,
  parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic [7:0] o_crc8,
  output logic       o_done,
  output logic       o_trunc
);

  localparam int CW = $clog2(DATA_LENGTH_BYTES + 1);
  localparam logic [7:0] CRC_INIT = 8'h0D;
  localparam logic [7:0] CRC_POLY = 8'hC6;

  typedef enum logic [1:0] {
    PASS,
    APPEND,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] count;
  logic          trunc_q;
  logic          out_free;
  logic          at_max;
  logic          load_pay;
  logic          load_crc;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] c_in,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] != d[i]) c = (c >> 1) ^ CRC_POLY;
      else              c = c >> 1;
    end
    return c;
  endfunction

  assign out_free = !o_valid || i_ready;
  assign at_max   = (count == CW'(DATA_LENGTH_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= PASS;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_done   = 1'b0;
    o_trunc  = 1'b0;
    load_pay = 1'b0;
    load_crc = 1'b0;
    unique case (state)
      PASS: begin
        o_ready = out_free && !reset;
        if (i_valid && out_free && !reset) begin
          load_pay = 1'b1;
          if (i_last || at_max) state_nx = APPEND;
        end
      end
      APPEND: begin
        if (out_free) begin
          load_crc = 1'b1;
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (o_valid && i_ready && !reset) begin
          o_done   = 1'b1;
          o_trunc  = trunc_q;
          state_nx = PASS;
        end
      end
      default: state_nx = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= 8'h00;
      o_last  <= 1'b0;
      o_crc8  <= CRC_INIT;
      count   <= '0;
      trunc_q <= 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (load_pay) begin
        o_valid <= 1'b1;
        o_data  <= i_data;
        o_last  <= 1'b0;
        o_crc8  <= crc8_byte(o_crc8, i_data);
        count   <= count + CW'(1);
        trunc_q <= !i_last && at_max;
      end
      if (load_crc) begin
        o_valid <= 1'b1;
        o_data  <= o_crc8;
        o_last  <= 1'b1;
      end
      // frame closed: rearm for the next one
      if (o_done) begin
        o_crc8  <= CRC_INIT;
        count   <= '0;
        trunc_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc8_tx_append.sv
// Directed bench for crc8_tx_append: pass-through, CRC append,
// truncation, stalls, back-to-back frames and mid-frame reset.
module tb_crc8_tx_append;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       i_ready;
  logic [7:0] o_crc8;
  logic       o_done;
  logic       o_trunc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_n;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cyc[$];
  logic [7:0] done_data[$];
  logic       done_trunc[$];

  crc8_tx_append #(.DATA_LENGTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_last (i_last),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last),
    .i_ready(i_ready),
    .o_crc8 (o_crc8),
    .o_done (o_done),
    .o_trunc(o_trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      got_data.push_back(o_data);
      got_last.push_back(o_last);
      got_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_data.push_back(o_data);
      done_trunc.push_back(o_trunc);
    end
  end

  task automatic clr();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    done_data.delete();
    done_trunc.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: o_ready=%b required=1", o_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_data.size() >= n) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_timeout: dones=%0d required=%0d",
               done_data.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (o_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got=%b want=0", o_ready);
    end
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got=%b want=0", o_valid);
    end
    total++;
    if (o_data !== 8'h00) begin
      bad++; $display("FAIL rst_data: got=%h want=00", o_data);
    end
    total++;
    if (o_last !== 1'b0) begin
      bad++; $display("FAIL rst_last: got=%b want=0", o_last);
    end
    total++;
    if ({o_done, o_trunc} !== 2'b00) begin
      bad++;
      $display("FAIL rst_pulses: got=%b%b want=00", o_done, o_trunc);
    end
    total++;
    if (o_crc8 !== 8'h0D) begin
      bad++; $display("FAIL rst_crc: got=%h want=0d", o_crc8);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL post_rst_ready: got=%b want=1", o_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_last_ignored();
    clr();
    i_last = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    i_last = 1'b0;
    total++;
    if (got_data.size() != 0) begin
      bad++;
      $display("FAIL last_ign_out: got=%0d bytes want=0", got_data.size());
    end
    total++;
    if (o_crc8 !== 8'h0D) begin
      bad++; $display("FAIL last_ign_crc: got=%h want=0d", o_crc8);
    end
  endtask

  task automatic test_single();
    clr();
    send(8'h00, 1'b1);
    wait_done(1);
    total++;
    if (got_data.size() != 2) begin
      bad++;
      $display("FAIL single_len: got=%0d want=2", got_data.size());
    end else begin
      total++;
      if ({got_data[0], got_last[0]} !== {8'h00, 1'b0}) begin
        bad++;
        $display("FAIL single_b0: got=%h/%b want=00/0",
                 got_data[0], got_last[0]);
      end
      total++;
      if ({got_data[1], got_last[1]} !== {8'hC7, 1'b1}) begin
        bad++;
        $display("FAIL single_crc: got=%h/%b want=c7/1",
                 got_data[1], got_last[1]);
      end
    end
    total++;
    if (done_data.size() != 1 || done_data[0] !== 8'hC7) begin
      bad++;
      $display("FAIL single_done: dones=%0d want 1 with c7",
               done_data.size());
    end
  endtask

  task automatic check_four(input string nm, input logic trunc);
    logic [7:0] exp[5];
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h71};
    total++;
    if (got_data.size() != 5) begin
      bad++;
      $display("FAIL %s_len: got=%0d want=5", nm, got_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if ({got_data[i], got_last[i]} !== {exp[i], (i == 4)}) begin
          bad++;
          $display("FAIL %s_b%0d: got=%h/%b want=%h/%b", nm, i,
                   got_data[i], got_last[i], exp[i], (i == 4));
        end
      end
    end
    total++;
    if (done_trunc.size() != 1 || done_trunc[0] !== trunc) begin
      bad++;
      $display("FAIL %s_trunc: dones=%0d want 1 with trunc=%b",
               nm, done_trunc.size(), trunc);
    end
  endtask

  task automatic test_four_last();
    clr();
    for (int i = 0; i < 4; i++) send(8'h00, i == 3);
    wait_done(1);
    check_four("four", 1'b0);
    total++;
    if (got_cyc.size() == 5 && got_cyc[4] - got_cyc[0] != 4) begin
      bad++;
      $display("FAIL four_gap: span=%0d want=4", got_cyc[4] - got_cyc[0]);
    end
    total++;
    if (o_crc8 !== 8'h0D) begin
      bad++; $display("FAIL four_reinit: got=%h want=0d", o_crc8);
    end
  endtask

  task automatic test_trunc();
    clr();
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
    wait_done(1);
    check_four("trunc", 1'b1);
  endtask

  task automatic stall_at(input int idx, input logic [7:0] v,
                          input logic l);
    for (int k = 0; k < 200 && stall_n < idx; k++) begin
      @(negedge clk);
      if (o_valid && i_ready) stall_n++;
    end
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_data, o_last, o_ready} !== {1'b1, v, l, 1'b0}) begin
        bad++;
        $display("FAIL stall%0d_c%0d: v/d/l/rdy=%b/%h/%b/%b want 1/%h/%b/0",
                 idx, s, o_valid, o_data, o_last, o_ready, v, l);
      end
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
  endtask

  task automatic test_stall();
    clr();
    stall_n = 0;
    fork
      for (int i = 0; i < 4; i++) send(8'h00, i == 3);
      begin
        stall_at(1, 8'h00, 1'b0);
        stall_at(4, 8'h71, 1'b1);
      end
    join
    wait_done(1);
    check_four("stall", 1'b0);
  endtask

  task automatic test_back_to_back();
    clr();
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    wait_done(2);
    total++;
    if (got_data.size() != 4) begin
      bad++;
      $display("FAIL b2b_len: got=%0d want=4", got_data.size());
    end else begin
      total++;
      if ({got_data[0], got_data[1], got_data[2], got_data[3]}
          !== 32'h00C7_00C7) begin
        bad++;
        $display("FAIL b2b_seq: got=%h %h %h %h want=00 c7 00 c7",
                 got_data[0], got_data[1], got_data[2], got_data[3]);
      end
    end
    total++;
    if (done_data.size() != 2 || done_data[1] !== 8'hC7) begin
      bad++;
      $display("FAIL b2b_done: dones=%0d want 2 ending c7",
               done_data.size());
    end
  endtask

  task automatic test_reset_mid();
    clr();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (got_last.size() > 0 && got_last[got_last.size()-1] !== 1'b0) begin
      bad++; $display("FAIL mid_crc_emitted: got o_last=1 want=0");
    end
    total++;
    if (o_crc8 !== 8'h0D) begin
      bad++; $display("FAIL mid_rst_crc: got=%h want=0d", o_crc8);
    end
    reset = 1'b0;
    clr();
    send(8'h00, 1'b1);
    wait_done(1);
    total++;
    if (got_data.size() != 2) begin
      bad++;
      $display("FAIL mid_len: got=%0d want=2", got_data.size());
    end else begin
      total++;
      if ({got_data[0], got_data[1], got_last[1]} !== {16'h00C7, 1'b1}) begin
        bad++;
        $display("FAIL mid_seq: got=%h %h/%b want=00 c7/1",
                 got_data[0], got_data[1], got_last[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_last_ignored();
    test_single();
    test_four_last();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
